// File: rtl/fu_pkg.sv
// rtl/fu_pkg.sv - shared types and latency table for the pipelined ALU functional unit
package fu_pkg;

  typedef enum logic [3:0] {
    ALU_NONE     = 4'd0,
    ALU_OR       = 4'd1,
    ALU_ADD      = 4'd2,
    ALU_XOR      = 4'd3,
    ALU_AND      = 4'd4,
    ALU_SUB      = 4'd5,
    ALU_SLT      = 4'd6,
    ALU_SLTU     = 4'd7,
    ALU_SLL      = 4'd9,
    ALU_SRL      = 4'd10,
    ALU_SRA      = 4'd11,
    ALU_PASS_RHS = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic valid;
    logic for_lsq;
  } slot_meta_t;

  function automatic int fu_latency(input logic [3:0] op, input int lat_logic,
                                    input int lat_add, input int lat_shift);
    case (op)
      ALU_OR, ALU_XOR, ALU_AND:             return lat_logic;
      ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU:  return lat_add;
      ALU_SLL, ALU_SRL, ALU_SRA:            return lat_shift;
      default:                              return 0;
    endcase
  endfunction

  function automatic logic fu_op_known(input logic [3:0] op);
    case (op)
      ALU_NONE, ALU_OR, ALU_ADD, ALU_XOR, ALU_AND, ALU_SUB, ALU_SLT, ALU_SLTU,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASS_RHS: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fu_alu_core.sv
// rtl/fu_alu_core.sv - combinational ALU datapath, (op, lhs, rhs) -> result
module fu_alu_core
  import fu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] lhs,
  input  logic [XLEN-1:0] rhs,
  output logic [XLEN-1:0] result
);

  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;
  assign shamt = rhs[SH_W-1:0];

  // NONE and unrecognised encodings both produce all-ones
  always_comb begin
    result = '1;
    case (op)
      ALU_OR:       result = lhs | rhs;
      ALU_AND:      result = lhs & rhs;
      ALU_XOR:      result = lhs ^ rhs;
      ALU_ADD:      result = lhs + rhs;
      ALU_SUB:      result = lhs - rhs;
      ALU_SLT:      result = {{(XLEN-1){1'b0}}, ($signed(lhs) < $signed(rhs))};
      ALU_SLTU:     result = {{(XLEN-1){1'b0}}, (lhs < rhs)};
      ALU_SLL:      result = lhs << shamt;
      ALU_SRL:      result = lhs >> shamt;
      ALU_SRA:      result = $unsigned($signed(lhs) >>> shamt);
      ALU_PASS_RHS: result = rhs;
      default:      result = '1;
    endcase
  end

endmodule

// File: rtl/pipelined_functional_unit.sv
// rtl/pipelined_functional_unit.sv - multi-slot pipelined ALU unit with oldest-first result broadcast
module pipelined_functional_unit
  import fu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 6,
  parameter int ROB_W     = 6,
  parameter int DEPTH     = 4,
  parameter int LAT_LOGIC = 1,
  parameter int LAT_ADD   = 2,
  parameter int LAT_SHIFT = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         write_enable,
  input  logic [3:0]                   alu_control,
  input  logic                         alu_src,
  input  logic                         is_for_lsq,
  input  logic [XLEN-1:0]              imm,
  input  logic [XLEN-1:0]              rs1_value,
  input  logic [XLEN-1:0]              rs2_value,
  input  logic [TAG_W-1:0]             tag_to_output,
  input  logic [ROB_W-1:0]             rob_index,
  output logic                         issue_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         wakeup_valid,
  input  logic                         wakeup_grant,
  output logic [TAG_W-1:0]             wakeup_tag,
  output logic [ROB_W-1:0]             wakeup_rob_index,
  output logic [XLEN-1:0]              wakeup_value,
  output logic                         lsq_valid,
  input  logic                         lsq_grant,
  output logic [ROB_W-1:0]             lsq_rob_index,
  output logic [XLEN-1:0]              lsq_value
);

  localparam int OCC_W   = $clog2(DEPTH+1);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int MAX_LAT = (LAT_SHIFT > LAT_ADD)
                         ? ((LAT_SHIFT > LAT_LOGIC) ? LAT_SHIFT : LAT_LOGIC)
                         : ((LAT_ADD > LAT_LOGIC) ? LAT_ADD : LAT_LOGIC);
  localparam int CNT_W   = $clog2(MAX_LAT+1);

  slot_meta_t       meta_q  [DEPTH];
  logic [TAG_W-1:0] tag_q   [DEPTH];
  logic [ROB_W-1:0] rob_q   [DEPTH];
  logic [XLEN-1:0]  value_q [DEPTH];
  logic [CNT_W-1:0] cnt_q   [DEPTH];
  // older_q[i][j] set means slot i was issued before slot j
  logic [DEPTH-1:0] older_q [DEPTH];

  logic             wk_hold_q, lsq_hold_q;
  logic [IDX_W-1:0] wk_hold_idx_q, lsq_hold_idx_q;

  logic [DEPTH-1:0] valid_vec, wk_cand, lsq_cand, wk_sel, lsq_sel, free_vec;
  logic [IDX_W-1:0] free_idx, wk_idx, lsq_idx;
  logic [OCC_W-1:0] occ;
  logic [XLEN-1:0]  rhs, alu_result;
  logic [CNT_W-1:0] issue_lat;
  logic             do_issue;

  assign rhs = alu_src ? imm : rs2_value;

  fu_alu_core #(.XLEN(XLEN)) u_alu (
    .op     (alu_control),
    .lhs    (rs1_value),
    .rhs    (rhs),
    .result (alu_result)
  );

  assign issue_lat = CNT_W'(fu_latency(alu_control, LAT_LOGIC, LAT_ADD, LAT_SHIFT));

  always_comb begin
    valid_vec = '0;
    wk_cand   = '0;
    lsq_cand  = '0;
    occ       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = meta_q[i].valid;
      wk_cand[i]   = meta_q[i].valid && (cnt_q[i] == '0) && !meta_q[i].for_lsq;
      lsq_cand[i]  = meta_q[i].valid && (cnt_q[i] == '0) && meta_q[i].for_lsq;
      occ          = occ + OCC_W'(meta_q[i].valid);
    end
  end

  assign occupancy   = occ;
  assign issue_ready = (occ != OCC_W'(DEPTH));
  assign do_issue    = write_enable && issue_ready && !flush;

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid_vec[i]) free_idx = IDX_W'(i);
    end
  end

  // A bus keeps presenting the same slot until it is granted, even if an older op finishes meanwhile
  always_comb begin
    wk_sel  = wk_cand;
    lsq_sel = lsq_cand;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && older_q[j][i]) begin
          if (wk_cand[j])  wk_sel[i]  = 1'b0;
          if (lsq_cand[j]) lsq_sel[i] = 1'b0;
        end
      end
    end
    if (wk_hold_q) begin
      wk_sel = '0;
      wk_sel[wk_hold_idx_q] = 1'b1;
    end
    if (lsq_hold_q) begin
      lsq_sel = '0;
      lsq_sel[lsq_hold_idx_q] = 1'b1;
    end
  end

  always_comb begin
    wk_idx           = '0;
    lsq_idx          = '0;
    wakeup_tag       = '0;
    wakeup_rob_index = '0;
    wakeup_value     = '0;
    lsq_rob_index    = '0;
    lsq_value        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wk_sel[i]) begin
        wk_idx           = wk_idx | IDX_W'(i);
        wakeup_tag       = wakeup_tag | tag_q[i];
        wakeup_rob_index = wakeup_rob_index | rob_q[i];
        wakeup_value     = wakeup_value | value_q[i];
      end
      if (lsq_sel[i]) begin
        lsq_idx       = lsq_idx | IDX_W'(i);
        lsq_rob_index = lsq_rob_index | rob_q[i];
        lsq_value     = lsq_value | value_q[i];
      end
    end
  end

  assign wakeup_valid = |wk_sel;
  assign lsq_valid    = |lsq_sel;
  assign free_vec     = (wk_sel & {DEPTH{wakeup_grant}}) | (lsq_sel & {DEPTH{lsq_grant}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        meta_q[i]  <= '0;
        tag_q[i]   <= '0;
        rob_q[i]   <= '0;
        value_q[i] <= '0;
        cnt_q[i]   <= '0;
        older_q[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        meta_q[i].valid <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (meta_q[i].valid && cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        if (free_vec[i]) meta_q[i].valid <= 1'b0;
        if (do_issue && free_idx == IDX_W'(i)) begin
          meta_q[i].valid   <= 1'b1;
          meta_q[i].for_lsq <= is_for_lsq;
          tag_q[i]          <= tag_to_output;
          rob_q[i]          <= rob_index;
          value_q[i]        <= alu_result;
          cnt_q[i]          <= issue_lat;
          older_q[i]        <= '0;
        end else if (do_issue) begin
          older_q[i][free_idx] <= meta_q[i].valid;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wk_hold_q      <= 1'b0;
      wk_hold_idx_q  <= '0;
      lsq_hold_q     <= 1'b0;
      lsq_hold_idx_q <= '0;
    end else if (flush) begin
      wk_hold_q  <= 1'b0;
      lsq_hold_q <= 1'b0;
    end else begin
      wk_hold_q      <= wakeup_valid && !wakeup_grant;
      wk_hold_idx_q  <= wk_idx;
      lsq_hold_q     <= lsq_valid && !lsq_grant;
      lsq_hold_idx_q <= lsq_idx;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && !flush && write_enable) begin
      if (!issue_ready)
        $warning("pipelined_functional_unit: issue while full, op dropped (tag %0d)", tag_to_output);
      else if (!fu_op_known(alu_control))
        $warning("pipelined_functional_unit: unknown alu_control %0d", alu_control);
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_functional_unit.sv
// tb/tb_pipelined_functional_unit.sv - self-checking bench for pipelined_functional_unit
module tb_pipelined_functional_unit;
  import fu_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0, reset = 1'b1, flush = 1'b0, write_enable = 1'b0;
  logic        alu_src = 1'b0, is_for_lsq = 1'b0, wakeup_grant = 1'b0, lsq_grant = 1'b0;
  logic [3:0]  alu_control = 4'd0;
  logic [31:0] imm = '0, rs1_value = '0, rs2_value = '0;
  logic [5:0]  tag_to_output = '0, rob_index = '0;
  logic        issue_ready, wakeup_valid, lsq_valid;
  logic [2:0]  occupancy;
  logic [5:0]  wakeup_tag, wakeup_rob_index, lsq_rob_index;
  logic [31:0] wakeup_value, lsq_value;

  pipelined_functional_unit dut (
    .clk(clk), .reset(reset), .flush(flush), .write_enable(write_enable),
    .alu_control(alu_control), .alu_src(alu_src), .is_for_lsq(is_for_lsq),
    .imm(imm), .rs1_value(rs1_value), .rs2_value(rs2_value),
    .tag_to_output(tag_to_output), .rob_index(rob_index),
    .issue_ready(issue_ready), .occupancy(occupancy),
    .wakeup_valid(wakeup_valid), .wakeup_grant(wakeup_grant), .wakeup_tag(wakeup_tag),
    .wakeup_rob_index(wakeup_rob_index), .wakeup_value(wakeup_value),
    .lsq_valid(lsq_valid), .lsq_grant(lsq_grant),
    .lsq_rob_index(lsq_rob_index), .lsq_value(lsq_value)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0, next_id = 0;
  int wk_lock = -1, lsq_lock = -1;
  bit checking = 1'b0;

  typedef struct {
    int        id;
    bit        lsq;
    bit [5:0]  tag;
    bit [5:0]  rob;
    bit [31:0] val;
    int        ready;
  } op_t;
  op_t mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit [31:0] model_alu(input bit [3:0] op, input bit [31:0] a, input bit [31:0] b);
    case (op)
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd4:  return a & b;
      4'd5:  return a - b;
      4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd9:  return a << b[4:0];
      4'd10: return a >> b[4:0];
      4'd11: return $unsigned($signed(a) >>> b[4:0]);
      4'd15: return b;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic int model_lat(input bit [3:0] op);
    case (op)
      4'd1, 4'd3, 4'd4:        return 1;
      4'd2, 4'd5, 4'd6, 4'd7:  return 2;
      4'd9, 4'd10, 4'd11:      return 4;
      default:                 return 0;
    endcase
  endfunction

  // Which queued op a bus presents: the one it is already showing, else the oldest finished one
  function automatic int pick(input bit lsq, input int lock_id);
    for (int i = 0; i < mq.size(); i++)
      if (lock_id >= 0 && mq[i].id == lock_id) return i;
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].lsq == lsq && mq[i].ready <= cyc) return i;
    return -1;
  endfunction

  initial forever begin
    op_t nq[$];
    op_t e;
    int  n0, wi, li;
    @(posedge clk or posedge reset);
    if (reset || flush) begin
      mq.delete();
      wk_lock  = -1;
      lsq_lock = -1;
    end else begin
      n0 = mq.size();
      wi = pick(1'b0, wk_lock);
      li = pick(1'b1, lsq_lock);
      wk_lock  = -1;
      lsq_lock = -1;
      if (wi >= 0 && !wakeup_grant) wk_lock = mq[wi].id;
      if (li >= 0 && !lsq_grant) lsq_lock = mq[li].id;
      nq.delete();
      for (int i = 0; i < mq.size(); i++)
        if (!((i == wi && wakeup_grant) || (i == li && lsq_grant))) nq.push_back(mq[i]);
      mq = nq;
      if (write_enable && n0 < DEPTH) begin
        e.id    = next_id++;
        e.lsq   = is_for_lsq;
        e.tag   = tag_to_output;
        e.rob   = rob_index;
        e.val   = model_alu(alu_control, rs1_value, alu_src ? imm : rs2_value);
        e.ready = cyc + 1 + model_lat(alu_control);
        mq.push_back(e);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    int wi, li;
    logic [5:0]  et, er, lr;
    logic [31:0] ev, lv;
    if (checking) begin
      wi = pick(1'b0, wk_lock);
      li = pick(1'b1, lsq_lock);
      et = '0; er = '0; ev = '0; lr = '0; lv = '0;
      if (wi >= 0) begin et = mq[wi].tag; er = mq[wi].rob; ev = mq[wi].val; end
      if (li >= 0) begin lr = mq[li].rob; lv = mq[li].val; end
      chk("issue_ready", issue_ready, mq.size() < DEPTH);
      chk("occupancy", occupancy, mq.size());
      chk("wakeup_valid", wakeup_valid, wi >= 0);
      chk("wakeup_tag", wakeup_tag, et);
      chk("wakeup_rob", wakeup_rob_index, er);
      chk("wakeup_value", wakeup_value, ev);
      chk("lsq_valid", lsq_valid, li >= 0);
      chk("lsq_rob", lsq_rob_index, lr);
      chk("lsq_value", lsq_value, lv);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input bit src, input bit lsq, input logic [5:0] tag);
    alu_control   = op;
    rs1_value     = a;
    rs2_value     = b;
    imm           = im;
    alu_src       = src;
    is_for_lsq    = lsq;
    tag_to_output = tag;
    rob_index     = ~tag;
    write_enable  = 1'b1;
    step();
    write_enable  = 1'b0;
  endtask

  logic [3:0]  op_tab  [8] = '{4'd0, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd4, 4'd8};
  logic [31:0] a_tab   [8] = '{32'd9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32'hF0F0, 32'd1};
  logic [31:0] b_tab   [8] = '{32'd9, 32'd5, 32'd1, 32'd1, 32'h3F, 32'd4, 32'hFF00, 32'd1};
  logic [31:0] exp_tab [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd0, 32'h8000_0000,
                               32'h0800_0000, 32'h0000_F000, 32'hFFFF_FFFF};

  initial begin
    int          got;
    logic [5:0]  seen_tag [2];
    logic [31:0] seen_val [2];
    bit          found;
    logic [31:0] fval;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_wakeup_valid", wakeup_valid, 0);
    chk("rst_wakeup_value", wakeup_value, 0);
    chk("rst_lsq_valid", lsq_valid, 0);
    chk("rst_lsq_value", lsq_value, 0);
    reset = 1'b0;
    checking = 1'b1;
    wakeup_grant = 1'b1;
    lsq_grant = 1'b1;
    step();

    // ADD 5+7 appears on wakeup exactly three cycles after the issue cycle
    issue(ALU_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 6'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t1_wakeup_valid", wakeup_valid, k == 3);
      if (k == 3) begin
        chk("t1_value", wakeup_value, 32'd12);
        chk("t1_tag", wakeup_tag, 6'd1);
      end
      chk("t1_lsq_valid", lsq_valid, 0);
      step();
    end

    issue(ALU_SRA, 32'h8000_0010, 32'h1F, 32'd4, 1'b1, 1'b1, 6'd2);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("t2_lsq_valid", lsq_valid, k == 5);
      if (k == 5) begin
        chk("t2_value", lsq_value, 32'hF800_0001);
        chk("t2_rob", lsq_rob_index, 6'h3D);
      end
      chk("t2_wakeup_valid", wakeup_valid, 0);
      step();
    end

    // Younger short-latency OR overtakes an older SRA
    issue(ALU_SRA, 32'hF0, 32'd2, 32'd0, 1'b0, 1'b0, 6'd3);
    issue(ALU_OR, 32'h0F, 32'hF0, 32'd0, 1'b0, 1'b0, 6'd4);
    got = 0;
    for (int k = 0; k < 12 && got < 2; k++) begin
      @(negedge clk);
      if (wakeup_valid) begin
        seen_tag[got] = wakeup_tag;
        seen_val[got] = wakeup_value;
        got++;
      end
      step();
    end
    chk("t3_count", got, 2);
    chk("t3_first_tag", seen_tag[0], 6'd4);
    chk("t3_first_value", seen_val[0], 32'hFF);
    chk("t3_second_tag", seen_tag[1], 6'd3);
    chk("t3_second_value", seen_val[1], 32'h3C);

    wakeup_grant = 1'b0;
    for (int t = 10; t <= 13; t++) issue(ALU_ADD, t, 32'd100, 32'd0, 1'b0, 1'b0, 6'(t));
    @(negedge clk);
    chk("t4_full_ready", issue_ready, 0);
    chk("t4_full_occ", occupancy, 4);
    step();
    issue(ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 6'd14);
    repeat (3) step();
    @(negedge clk);
    chk("t4_oldest_tag", wakeup_tag, 6'd10);
    chk("t4_oldest_value", wakeup_value, 32'd110);
    step();
    wakeup_grant = 1'b1;
    step();
    wakeup_grant = 1'b0;
    @(negedge clk);
    chk("t4_ready_after_grant", issue_ready, 1);
    chk("t4_occ_after_grant", occupancy, 3);
    chk("t4_next_tag", wakeup_tag, 6'd11);
    step();
    wakeup_grant = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("t4_drained_occ", occupancy, 0);
    step();

    wakeup_grant = 1'b0;
    lsq_grant = 1'b0;
    issue(ALU_OR, 32'hA0, 32'h0B, 32'd0, 1'b0, 1'b1, 6'd20);
    issue(ALU_XOR, 32'hFF, 32'h0F, 32'd0, 1'b0, 1'b0, 6'd21);
    step();
    @(negedge clk);
    chk("t5_both_wk_valid", wakeup_valid, 1);
    chk("t5_both_lsq_valid", lsq_valid, 1);
    chk("t5_wk_value", wakeup_value, 32'hF0);
    chk("t5_lsq_value", lsq_value, 32'hAB);
    chk("t5_occ_before", occupancy, 2);
    wakeup_grant = 1'b1;
    lsq_grant = 1'b1;
    step();
    @(negedge clk);
    chk("t5_occ_after", occupancy, 0);
    chk("t5_wk_after", wakeup_valid, 0);
    chk("t5_lsq_after", lsq_valid, 0);
    step();

    // Flush with a concurrent issue; then an asynchronous reset mid-flight
    wakeup_grant = 1'b0;
    for (int t = 30; t <= 32; t++) issue(ALU_ADD, t, 32'd1, 32'd0, 1'b0, 1'b0, 6'(t));
    flush = 1'b1;
    issue(ALU_ADD, 32'd2, 32'd2, 32'd0, 1'b0, 1'b0, 6'd33);
    flush = 1'b0;
    @(negedge clk);
    chk("t6_flush_occ", occupancy, 0);
    chk("t6_flush_ready", issue_ready, 1);
    chk("t6_flush_wk", wakeup_valid, 0);
    repeat (3) step();
    @(negedge clk);
    chk("t6_flush_later_wk", wakeup_valid, 0);
    step();
    issue(ALU_ADD, 32'd4, 32'd4, 32'd0, 1'b0, 1'b0, 6'd40);
    issue(ALU_SLL, 32'd4, 32'd1, 32'd0, 1'b0, 1'b1, 6'd41);
    #2 reset = 1'b1;
    #1;
    chk("t6_reset_occ", occupancy, 0);
    chk("t6_reset_ready", issue_ready, 1);
    step();
    reset = 1'b0;
    wakeup_grant = 1'b1;
    @(negedge clk);
    chk("t6_post_reset_wk", wakeup_valid, 0);
    step();
    issue(ALU_PASS_RHS, 32'd0, 32'h1234, 32'd0, 1'b0, 1'b0, 6'd50);
    @(negedge clk);
    chk("t6_pass_valid", wakeup_valid, 1);
    chk("t6_pass_value", wakeup_value, 32'h1234);
    step();

    for (int i = 0; i < 8; i++) begin
      issue(op_tab[i], a_tab[i], b_tab[i], 32'd0, 1'b0, 1'b0, 6'(32 + i));
      found = 1'b0;
      fval = '0;
      for (int k = 0; k < 8 && !found; k++) begin
        @(negedge clk);
        if (wakeup_valid && wakeup_tag == 6'(32 + i)) begin
          found = 1'b1;
          fval = wakeup_value;
        end
        step();
      end
      chk("t7_op_seen", found, 1);
      chk("t7_op_value", fval, exp_tab[i]);
    end

    // Back-to-back burst over both buses, including issues while full
    for (int i = 0; i < 12; i++)
      issue(op_tab[i % 8] == 4'd8 ? ALU_SRA : op_tab[i % 8], a_tab[i % 8] + i, b_tab[i % 8],
            32'd0, 1'b0, i[0], 6'(48 + i));
    repeat (10) step();
    @(negedge clk);
    chk("t8_drained", occupancy, 0);

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
